// File: rtl/strv32i_pkg.sv
// ----------------------------------------------------------------------------
// strv32i_pkg
// Shared definitions for the STRV32I load/store unit:
//   - load/store size encodings (LS_BYTE / LS_HALF / LS_WORD; 2'b11 is
//     reserved and handled as a word)
//   - LSU FSM state encoding (ST_IDLE, ST_BUSY)
//   - width of the optional bus timeout counter
//   - helpers for byte-enable generation and store-lane replication
// ----------------------------------------------------------------------------
package strv32i_pkg;

    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10
    } ls_size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } lsu_state_e;

    localparam int TIMEOUT_CNT_W = 8;

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                                input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            LS_BYTE: be = 4'b0001 << offset;
            LS_HALF: be = 4'b0011 << {offset[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store operand across every lane it could land in, so the
    // byte enables alone select the written bytes.
    function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                                input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            LS_BYTE: lanes = {4{data[7:0]}};
            LS_HALF: lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// ----------------------------------------------------------------------------
// lsu_load_align
// Combinational load-data alignment: shifts the addressed byte/half/word down
// to bit 0 and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata_in     32  raw word returned by the data bus
//   offset_in     2  byte offset within the word (addr[1:0])
//   size_in       2  LS_BYTE / LS_HALF / LS_WORD (2'b11 handled as word)
//   unsigned_in   1  1 = zero-extend, 0 = sign-extend
//   load_data_o  32  aligned, extended result
// ----------------------------------------------------------------------------
module lsu_load_align
    import strv32i_pkg::*;
(
    input  logic [31:0] rdata_in,
    input  logic [1:0]  offset_in,
    input  logic [1:0]  size_in,
    input  logic        unsigned_in,
    output logic [31:0] load_data_o
);

    logic [31:0] shifted;
    logic        sign_bit;

    always_comb begin
        shifted  = rdata_in >> {offset_in, 3'b000};
        sign_bit = 1'b0;
        case (size_in)
            LS_BYTE: begin
                sign_bit    = ~unsigned_in & shifted[7];
                load_data_o = {{24{sign_bit}}, shifted[7:0]};
            end
            LS_HALF: begin
                sign_bit    = ~unsigned_in & shifted[15];
                load_data_o = {{16{sign_bit}}, shifted[15:0]};
            end
            default: load_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// ----------------------------------------------------------------------------
// lsu_mem_stage
// Memory-access stage of the STRV32I pipeline. Issues one outstanding access
// at a time on a req/ready data bus, stalls the pipeline while it is in
// flight, and returns aligned/extended load data to write-back.
// Optional feature: define LSU_TIMEOUT_EN to abort an access that has waited
// TIMEOUT_CYCLES BUSY cycles without dmem_ready_in (bus_err_o pulses).
// Ports:
//   clk_in, rst_in (async, active-low)
//   mem_rd_req_in / mem_wr_req_in, addr_in, rs2_in, load_size_in,
//   load_unsigned_in                      - request from execute
//   dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
//   dmem_ready_in, dmem_rdata_in          - data-memory bus
//   lsu_stall_o                           - hold upstream registers
//   load_data_o, load_valid_o             - load result to write-back
//   misaligned_o, bus_err_o               - one-cycle error pulses
// ----------------------------------------------------------------------------
module lsu_mem_stage
    import strv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        mem_rd_req_in,
    input  logic        mem_wr_req_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] rs2_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_ready_in,
    input  logic [31:0] dmem_rdata_in,
    output logic        lsu_stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        misaligned_o,
    output logic        bus_err_o
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  offset_q, offset_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        misaligned_q, misaligned_d;

    logic        req;
    logic        misaligned;
    logic        start;
    logic        timeout_hit;
    logic [31:0] aligned_data;

    assign req        = mem_rd_req_in | mem_wr_req_in;
    // load_size_in[1] covers both word and the reserved encoding.
    assign misaligned = ((load_size_in == LS_HALF) & addr_in[0]) |
                        (load_size_in[1] & (addr_in[1:0] != 2'b00));
    assign start      = (state_q == ST_IDLE) & req & ~misaligned;

`ifdef LSU_TIMEOUT_EN
    localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_CNT_W-1:0] cnt_q, cnt_d;
    logic                     bus_err_q, bus_err_d;

    // The limit is reached on the BUSY cycle whose increment would make the
    // count equal TIMEOUT_CYCLES; a ready on that same cycle takes priority.
    assign timeout_hit = (state_q == ST_BUSY) & ~dmem_ready_in & (cnt_q == TIMEOUT_LAST);

    always_comb begin
        cnt_d     = cnt_q;
        bus_err_d = timeout_hit;
        if (start) begin
            cnt_d = '0;
        end else if ((state_q == ST_BUSY) & ~dmem_ready_in) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err_o = bus_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus_err_o   = 1'b0;
`endif

    lsu_load_align u_load_align (
        .rdata_in    (dmem_rdata_in),
        .offset_in   (offset_q),
        .size_in     (size_q),
        .unsigned_in (unsigned_q),
        .load_data_o (aligned_data)
    );

    // NOTE: every signal assigned below gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        offset_d     = offset_q;
        unsigned_d   = unsigned_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        misaligned_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req && misaligned) begin
                    misaligned_d = 1'b1;
                end else if (start) begin
                    state_d    = ST_BUSY;
                    addr_d     = {addr_in[31:2], 2'b00};
                    // A simultaneous read and write request is a store.
                    we_d       = mem_wr_req_in;
                    be_d       = byte_enables(load_size_in, addr_in[1:0]);
                    wdata_d    = store_lanes(load_size_in, rs2_in);
                    size_d     = load_size_in;
                    offset_d   = addr_in[1:0];
                    unsigned_d = load_unsigned_in;
                end
            end
            ST_BUSY: begin
                if (dmem_ready_in) begin
                    state_d = ST_IDLE;
                    if (!we_q) begin
                        load_data_d  = aligned_data;
                        load_valid_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of order.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            offset_q     <= '0;
            unsigned_q   <= 1'b0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            offset_q     <= offset_d;
            unsigned_q   <= unsigned_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign dmem_req_o   = (state_q == ST_BUSY);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign dmem_be_o    = be_q;
    assign load_data_o  = load_data_q;
    assign load_valid_o = load_valid_q;
    assign misaligned_o = misaligned_q;

    // Stall while an aligned request waits to launch and while the bus has
    // not answered; released on the completing (or aborting) cycle.
    assign lsu_stall_o = start |
                         ((state_q == ST_BUSY) & ~dmem_ready_in & ~timeout_hit);

endmodule

// File: tb/tb_lsu_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_lsu_mem_stage
// Directed self-checking bench for lsu_mem_stage. Inputs change just after
// the falling edge; outputs are sampled a couple of time units later, well
// away from the rising (active) edge. Build with +define+LSU_TIMEOUT_EN to
// exercise the bus timeout (TIMEOUT_CYCLES is overridden to 4).
// ----------------------------------------------------------------------------
module tb_lsu_mem_stage;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        mem_rd_req_in, mem_wr_req_in;
    logic [31:0] addr_in, rs2_in;
    logic [1:0]  load_size_in;
    logic        load_unsigned_in;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ready_in;
    logic [31:0] dmem_rdata_in;
    logic        lsu_stall_o;
    logic [31:0] load_data_o;
    logic        load_valid_o, misaligned_o, bus_err_o;

    int checks   = 0;
    int failures = 0;

    // Observations gathered by run_access.
    int          o_stalls, o_busy;
    logic        o_req_seen, o_we, o_lv, o_lv2, o_mis, o_mis2, o_berr, o_berr_any;
    logic [31:0] o_addr, o_wdata, o_ld;
    logic [3:0]  o_be;

    always #5 clk_in = ~clk_in;

    lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .mem_rd_req_in    (mem_rd_req_in),
        .mem_wr_req_in    (mem_wr_req_in),
        .addr_in          (addr_in),
        .rs2_in           (rs2_in),
        .load_size_in     (load_size_in),
        .load_unsigned_in (load_unsigned_in),
        .dmem_req_o       (dmem_req_o),
        .dmem_we_o        (dmem_we_o),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_wdata_o     (dmem_wdata_o),
        .dmem_be_o        (dmem_be_o),
        .dmem_ready_in    (dmem_ready_in),
        .dmem_rdata_in    (dmem_rdata_in),
        .lsu_stall_o      (lsu_stall_o),
        .load_data_o      (load_data_o),
        .load_valid_o     (load_valid_o),
        .misaligned_o     (misaligned_o),
        .bus_err_o        (bus_err_o)
    );

    // Drive one request, hold it while stalled, assert ready after `waits`
    // BUSY cycles, and record what the DUT did. Bounded to 40 cycles.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] rs2, input logic [1:0] size,
                              input logic uns, input logic [31:0] rdata, input int waits);
        logic done = 1'b0;
        o_stalls = 0; o_busy = 0; o_req_seen = 1'b0; o_berr_any = 1'b0;
        o_addr = '0; o_be = '0; o_wdata = '0; o_we = 1'b0;
        @(negedge clk_in);
        mem_rd_req_in = rd; mem_wr_req_in = wr; addr_in = addr; rs2_in = rs2;
        load_size_in = size; load_unsigned_in = uns; dmem_rdata_in = rdata;
        dmem_ready_in = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (dmem_req_o) begin
                o_req_seen = 1'b1;
                o_addr = dmem_addr_o; o_be = dmem_be_o; o_wdata = dmem_wdata_o; o_we = dmem_we_o;
                dmem_ready_in = (o_busy == waits);
                o_busy++;
            end else begin
                dmem_ready_in = 1'b0;
            end
            #1;
            if (bus_err_o) o_berr_any = 1'b1;
            if (lsu_stall_o) o_stalls++;
            else done = 1'b1;
            @(negedge clk_in);
        end
        mem_rd_req_in = 1'b0; mem_wr_req_in = 1'b0; dmem_ready_in = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL access_bound: stall still high after 40 cycles, required release");
        end
        #1;
        o_lv = load_valid_o; o_ld = load_data_o; o_mis = misaligned_o; o_berr = bus_err_o;
        @(negedge clk_in);
        #1;
        o_lv2 = load_valid_o; o_mis2 = misaligned_o;
    endtask

    task automatic test_reset;
        rst_in = 1'b0;
        mem_rd_req_in = 1'b0; mem_wr_req_in = 1'b0; addr_in = '0; rs2_in = '0;
        load_size_in = '0; load_unsigned_in = 1'b0; dmem_ready_in = 1'b0; dmem_rdata_in = '0;
        @(negedge clk_in); @(negedge clk_in); #1;
        checks++; if (dmem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req: got %b required 0", dmem_req_o); end
        checks++; if (lsu_stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b required 0", lsu_stall_o); end
        checks++; if ({dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o} !== '0) begin failures++; $display("FAIL reset_bus: got we=%b be=%b addr=%h wdata=%h required all 0", dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o); end
        checks++; if ({load_valid_o, misaligned_o, bus_err_o} !== 3'b000) begin failures++; $display("FAIL reset_pulses: got lv=%b mis=%b berr=%b required 000", load_valid_o, misaligned_o, bus_err_o); end
        checks++; if (load_data_o !== 32'h0) begin failures++; $display("FAIL reset_load_data: got %h required 0", load_data_o); end
        rst_in = 1'b1;
    endtask

    task automatic test_lb_signed;
        run_access(1'b1, 1'b0, 32'h0000_0103, 32'h0, 2'b00, 1'b0, 32'h80AA_BBCC, 2);
        checks++; if (o_be !== 4'b1000) begin failures++; $display("FAIL lb_be: got %b required 1000", o_be); end
        checks++; if (o_addr !== 32'h0000_0100) begin failures++; $display("FAIL lb_addr: got %h required 00000100", o_addr); end
        checks++; if (o_we !== 1'b0) begin failures++; $display("FAIL lb_we: got %b required 0", o_we); end
        checks++; if (o_stalls != 3) begin failures++; $display("FAIL lb_stall_cycles: got %0d required 3", o_stalls); end
        checks++; if (o_lv !== 1'b1) begin failures++; $display("FAIL lb_valid: got %b required 1", o_lv); end
        checks++; if (o_ld !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data: got %h required ffffff80", o_ld); end
        checks++; if (o_lv2 !== 1'b0) begin failures++; $display("FAIL lb_valid_pulse: got %b required 0 one cycle later", o_lv2); end
    endtask

    task automatic test_lhu;
        run_access(1'b1, 1'b0, 32'h0000_0102, 32'h0, 2'b01, 1'b1, 32'h8001_1234, 0);
        checks++; if (o_stalls != 1) begin failures++; $display("FAIL lhu_stall_cycles: got %0d required 1", o_stalls); end
        checks++; if (o_be !== 4'b1100) begin failures++; $display("FAIL lhu_be: got %b required 1100", o_be); end
        checks++; if (o_lv !== 1'b1) begin failures++; $display("FAIL lhu_valid: got %b required 1", o_lv); end
        checks++; if (o_ld !== 32'h0000_8001) begin failures++; $display("FAIL lhu_data: got %h required 00008001", o_ld); end
    endtask

    task automatic test_other_loads;
        run_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2'b01, 1'b0, 32'h1234_9ABC, 1);
        checks++; if (o_be !== 4'b0011) begin failures++; $display("FAIL lh_be: got %b required 0011", o_be); end
        checks++; if (o_ld !== 32'hFFFF_9ABC) begin failures++; $display("FAIL lh_data: got %h required ffff9abc", o_ld); end
        run_access(1'b1, 1'b0, 32'h0000_0101, 32'h0, 2'b00, 1'b1, 32'h0000_80FF, 0);
        checks++; if (o_ld !== 32'h0000_0080) begin failures++; $display("FAIL lbu_data: got %h required 00000080", o_ld); end
        // Reserved size encoding behaves as a full word.
        run_access(1'b1, 1'b0, 32'h0000_0404, 32'h0, 2'b11, 1'b0, 32'h89AB_CDEF, 0);
        checks++; if (o_be !== 4'b1111) begin failures++; $display("FAIL lw_rsvd_be: got %b required 1111", o_be); end
        checks++; if (o_ld !== 32'h89AB_CDEF) begin failures++; $display("FAIL lw_rsvd_data: got %h required 89abcdef", o_ld); end
    endtask

    task automatic test_stores;
        run_access(1'b0, 1'b1, 32'h0000_0201, 32'h1234_5678, 2'b00, 1'b0, 32'hFFFF_FFFF, 0);
        checks++; if (o_addr !== 32'h0000_0200) begin failures++; $display("FAIL sb_addr: got %h required 00000200", o_addr); end
        checks++; if (o_be !== 4'b0010) begin failures++; $display("FAIL sb_be: got %b required 0010", o_be); end
        checks++; if (o_wdata !== 32'h7878_7878) begin failures++; $display("FAIL sb_wdata: got %h required 78787878", o_wdata); end
        checks++; if (o_we !== 1'b1) begin failures++; $display("FAIL sb_we: got %b required 1", o_we); end
        checks++; if (o_lv !== 1'b0) begin failures++; $display("FAIL sb_no_valid: got %b required 0", o_lv); end
        // Read and write together: a store.
        run_access(1'b1, 1'b1, 32'h0000_0206, 32'hAAAA_5555, 2'b01, 1'b0, 32'hFFFF_FFFF, 1);
        checks++; if ({o_we, o_be} !== 5'b1_1100) begin failures++; $display("FAIL sh_rdwr_we_be: got we=%b be=%b required we=1 be=1100", o_we, o_be); end
        checks++; if (o_wdata !== 32'h5555_5555) begin failures++; $display("FAIL sh_rdwr_wdata: got %h required 55555555", o_wdata); end
        checks++; if (o_addr !== 32'h0000_0204) begin failures++; $display("FAIL sh_rdwr_addr: got %h required 00000204", o_addr); end
        checks++; if (o_lv !== 1'b0) begin failures++; $display("FAIL sh_rdwr_no_valid: got %b required 0", o_lv); end
    endtask

    task automatic test_misaligned;
        run_access(1'b1, 1'b0, 32'h0000_0302, 32'h0, 2'b10, 1'b0, 32'h0, 0);
        checks++; if (o_req_seen !== 1'b0) begin failures++; $display("FAIL mis_lw_req: got %b required 0", o_req_seen); end
        checks++; if (o_stalls != 0) begin failures++; $display("FAIL mis_lw_stall: got %0d required 0", o_stalls); end
        checks++; if ({o_mis, o_mis2} !== 2'b10) begin failures++; $display("FAIL mis_lw_pulse: got %b%b required 10", o_mis, o_mis2); end
        checks++; if (o_lv !== 1'b0) begin failures++; $display("FAIL mis_lw_no_valid: got %b required 0", o_lv); end
        run_access(1'b0, 1'b1, 32'h0000_0101, 32'h0, 2'b01, 1'b0, 32'h0, 0);
        checks++; if ({o_req_seen, o_stalls[0], o_mis} !== 3'b001) begin failures++; $display("FAIL mis_sh: got req=%b stall=%0d mis=%b required 0 0 1", o_req_seen, o_stalls, o_mis); end
    endtask

    task automatic test_reset_busy;
        @(negedge clk_in);
        mem_rd_req_in = 1'b1; addr_in = 32'h0000_0100; load_size_in = 2'b10;
        load_unsigned_in = 1'b0; dmem_rdata_in = 32'h1111_2222; dmem_ready_in = 1'b0;
        @(negedge clk_in); #1;
        checks++; if (dmem_req_o !== 1'b1) begin failures++; $display("FAIL rstb_busy: got req=%b required 1", dmem_req_o); end
        rst_in = 1'b0; mem_rd_req_in = 1'b0;
        #1;
        checks++; if ({dmem_req_o, lsu_stall_o} !== 2'b00) begin failures++; $display("FAIL rstb_abort: got req=%b stall=%b required 0 0", dmem_req_o, lsu_stall_o); end
        dmem_ready_in = 1'b1;
        @(negedge clk_in); #1;
        rst_in = 1'b1;
        @(negedge clk_in); #1;
        checks++; if (load_valid_o !== 1'b0) begin failures++; $display("FAIL rstb_no_valid: got %b required 0", load_valid_o); end
        dmem_ready_in = 1'b0;
        run_access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1);
        checks++; if (o_stalls != 2) begin failures++; $display("FAIL rstb_next_stall: got %0d required 2", o_stalls); end
        checks++; if ({o_lv, o_ld} !== {1'b1, 32'hDEAD_BEEF}) begin failures++; $display("FAIL rstb_next_load: got lv=%b data=%h required 1 deadbeef", o_lv, o_ld); end
    endtask

    task automatic test_timeout;
`ifdef LSU_TIMEOUT_EN
        run_access(1'b1, 1'b0, 32'h0000_0500, 32'h0, 2'b10, 1'b0, 32'h0, 100);
        checks++; if (o_busy != 4) begin failures++; $display("FAIL to_busy_cycles: got %0d required 4", o_busy); end
        checks++; if (o_stalls != 4) begin failures++; $display("FAIL to_stall_cycles: got %0d required 4", o_stalls); end
        checks++; if ({o_berr, o_lv} !== 2'b10) begin failures++; $display("FAIL to_err: got berr=%b lv=%b required 1 0", o_berr, o_lv); end
        checks++; if (dmem_req_o !== 1'b0) begin failures++; $display("FAIL to_idle: got req=%b required 0", dmem_req_o); end
        // Ready on the limit cycle completes normally.
        run_access(1'b1, 1'b0, 32'h0000_0500, 32'h0, 2'b10, 1'b0, 32'hCAFE_F00D, 3);
        checks++; if ({o_berr, o_lv, o_ld} !== {1'b0, 1'b1, 32'hCAFE_F00D}) begin failures++; $display("FAIL to_ready_wins: got berr=%b lv=%b data=%h required 0 1 cafef00d", o_berr, o_lv, o_ld); end
`else
        run_access(1'b1, 1'b0, 32'h0000_0500, 32'h0, 2'b10, 1'b0, 32'hCAFE_F00D, 10);
        checks++; if (o_stalls != 11) begin failures++; $display("FAIL nto_stall_cycles: got %0d required 11", o_stalls); end
        checks++; if ({o_berr_any, o_berr} !== 2'b00) begin failures++; $display("FAIL nto_no_err: got %b%b required 00", o_berr_any, o_berr); end
        checks++; if ({o_lv, o_ld} !== {1'b1, 32'hCAFE_F00D}) begin failures++; $display("FAIL nto_load: got lv=%b data=%h required 1 cafef00d", o_lv, o_ld); end
`endif
    endtask

    initial begin
        test_reset;
        test_lb_signed;
        test_lhu;
        test_other_loads;
        test_stores;
        test_misaligned;
        test_reset_busy;
        test_timeout;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
